// File: rtl/life_pkg.sv
// Shared types and default sizing for the Game-of-Life board controller.
package life_pkg;

  typedef enum logic [1:0] {
    PAUSED  = 2'd0,
    RUNNING = 2'd1,
    HALTED  = 2'd2
  } life_state_e;

  localparam int unsigned LIFE_N_DEFAULT        = 5;
  localparam int unsigned LIFE_TICK_DIV_DEFAULT = 4;
  localparam int unsigned LIFE_GEN_W_DEFAULT    = 16;

endpackage

// File: rtl/life_tick_div.sv
// Generation pacing counter: counts 0..P_TICK_DIV-1 while enabled and
// flags the terminal count with a one-cycle tick before wrapping to zero.
// The count holds while disabled so a paused run can be resumed cleanly.
module life_tick_div #(
  parameter int unsigned P_TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (P_TICK_DIV > 1) ? $clog2(P_TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(P_TICK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick = enable && (count_q == TERM);

  // Next count: restart wins, otherwise advance (and wrap) only while enabled.
  always_comb begin
    count_d = count_q;
    if (restart) begin
      count_d = '0;
    end else if (enable) begin
      count_d = tick ? '0 : count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/life_board_ctrl.sv
// Board register and run/pause/step/halt sequencer for the Game-of-Life
// datapath. The board is driven out as evo_prev; the external combinational
// evolution stage returns evo_next, which is committed on each generation.
module life_board_ctrl
  import life_pkg::*;
#(
  parameter int unsigned P_PARAM_N  = LIFE_N_DEFAULT,
  parameter int unsigned P_TICK_DIV = LIFE_TICK_DIV_DEFAULT,
  parameter int unsigned P_GEN_W    = LIFE_GEN_W_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 cmd_run,
  input  logic                                 cmd_pause,
  input  logic                                 cmd_step,
  input  logic                                 cmd_clear,
  input  logic                                 edit_valid,
  input  logic [$clog2(P_PARAM_N)-1:0]         edit_row,
  input  logic [$clog2(P_PARAM_N)-1:0]         edit_col,
  input  logic                                 edit_value,
  output logic [P_PARAM_N-1:0][P_PARAM_N-1:0]  evo_prev,
  input  logic [P_PARAM_N-1:0][P_PARAM_N-1:0]  evo_next,
  output logic                                 running,
  output logic                                 halted,
  output logic [P_GEN_W-1:0]                   gen_count,
  output logic                                 gen_tick
);

  life_state_e                          state_q, state_d;
  logic [P_PARAM_N-1:0][P_PARAM_N-1:0]  board_q, board_d;
  logic [P_GEN_W-1:0]                   gen_q, gen_d;
  logic                                 gen_tick_q;

  logic tick, tick_enable, tick_restart;
  logic edit_in_range, edit_ok, pause_ok, run_ok, step_ok;
  logic commit, halt_cond;

  // A command is dropped whenever any higher-priority input is present in
  // the same cycle, even if that higher-priority input itself has no effect.
  assign edit_in_range = (32'(edit_row) < P_PARAM_N) && (32'(edit_col) < P_PARAM_N);
  assign edit_ok  = edit_valid && !cmd_clear && (state_q != RUNNING) && edit_in_range;
  assign pause_ok = cmd_pause && !cmd_clear && !edit_valid;
  assign run_ok   = cmd_run && !cmd_clear && !edit_valid && !cmd_pause;
  assign step_ok  = cmd_step && !cmd_clear && !edit_valid && !cmd_pause && !cmd_run;

  assign tick_enable  = (state_q == RUNNING);
  assign tick_restart = cmd_clear || ((state_q == PAUSED) && run_ok);

  // Clear suppresses any generation that would otherwise land this cycle.
  assign commit    = !cmd_clear && (((state_q == RUNNING) && tick) ||
                                    ((state_q == PAUSED) && step_ok));
  assign halt_cond = (evo_next == board_q) || (evo_next == '0);

  life_tick_div #(
    .P_TICK_DIV (P_TICK_DIV)
  ) u_tick_div (
    .clk     (clk),
    .reset   (reset),
    .enable  (tick_enable),
    .restart (tick_restart),
    .tick    (tick)
  );

  // Next-state logic; an explicit pause outranks an automatic halt.
  always_comb begin
    state_d = state_q;
    if (cmd_clear) begin
      state_d = PAUSED;
    end else begin
      unique case (state_q)
        PAUSED: begin
          if (run_ok) state_d = RUNNING;
        end
        RUNNING: begin
          if (pause_ok) begin
            state_d = PAUSED;
          end else if (commit && halt_cond) begin
            state_d = HALTED;
          end
        end
        HALTED: begin
          if (edit_ok) state_d = PAUSED;
        end
        default: state_d = PAUSED;
      endcase
    end
  end

  // Board and generation counter updates: clear, then commit, then edit.
  always_comb begin
    board_d = board_q;
    gen_d   = gen_q;
    if (cmd_clear) begin
      board_d = '0;
      gen_d   = '0;
    end else if (commit) begin
      board_d = evo_next;
      gen_d   = gen_q + 1'b1;
    end else if (edit_ok) begin
      board_d[edit_row][edit_col] = edit_value;
    end
  end

  // State, board, counter and the commit-following tick pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= PAUSED;
      board_q    <= '0;
      gen_q      <= '0;
      gen_tick_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      gen_q      <= gen_d;
      gen_tick_q <= commit;
    end
  end

  assign evo_prev  = board_q;
  assign running   = (state_q == RUNNING);
  assign halted    = (state_q == HALTED);
  assign gen_count = gen_q;
  assign gen_tick  = gen_tick_q;

endmodule

// File: tb/tb_life_board_ctrl.sv
// Self-checking bench for life_board_ctrl: an in-bench Game-of-Life stage
// closes the loop, and a behavioural model tracks the expected board,
// mode, generation count and tick pulse every cycle.
module tb_life_board_ctrl;

  localparam int N   = 5;
  localparam int DIV = 4;
  localparam int GW  = 16;

  typedef logic [N-1:0][N-1:0] boardT;
  typedef enum int {M_PAUSED, M_RUNNING, M_HALTED} modeT;

  logic          clock = 1'b0;
  logic          reset;
  logic          cmdRun, cmdPause, cmdStep, cmdClear;
  logic          editValid, editValue;
  logic [2:0]    editRow, editCol;
  boardT         evoPrev, evoNext;
  logic          running, halted, genTick;
  logic [GW-1:0] genCount;

  boardT mBoard;
  modeT  mMode;
  int    mPhase;
  int    mGen;
  bit    mTick;

  int checkCount = 0;
  int passCount  = 0;

  life_board_ctrl #(
    .P_PARAM_N  (N),
    .P_TICK_DIV (DIV),
    .P_GEN_W    (GW)
  ) dut (
    .clk        (clock),
    .reset      (reset),
    .cmd_run    (cmdRun),
    .cmd_pause  (cmdPause),
    .cmd_step   (cmdStep),
    .cmd_clear  (cmdClear),
    .edit_valid (editValid),
    .edit_row   (editRow),
    .edit_col   (editCol),
    .edit_value (editValue),
    .evo_prev   (evoPrev),
    .evo_next   (evoNext),
    .running    (running),
    .halted     (halted),
    .gen_count  (genCount),
    .gen_tick   (genTick)
  );

  always #5 clock = ~clock;

  // Conway's rule on a bounded board: cells beyond the edge are dead.
  function automatic boardT lifeNext(input boardT b);
    boardT r;
    int n;
    r = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        n = 0;
        for (int di = -1; di <= 1; di++) begin
          for (int dj = -1; dj <= 1; dj++) begin
            if ((di != 0 || dj != 0) && (i + di >= 0) && (i + di < N) &&
                (j + dj >= 0) && (j + dj < N)) begin
              n += int'(b[i+di][j+dj]);
            end
          end
        end
        r[i][j] = (n == 3) || (b[i][j] && n == 2);
      end
    end
    return r;
  endfunction

  // The evolution stage the parent would normally provide.
  always_comb evoNext = lifeNext(evoPrev);

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mBoard = '0;
    mMode  = M_PAUSED;
    mPhase = 0;
    mGen   = 0;
    mTick  = 0;
  endtask

  // One clock edge of intended behaviour given the inputs sampled there.
  task automatic modelStep(input bit run, input bit pause, input bit step, input bit clear,
                           input bit ev, input int row, input int col, input bit val);
    boardT nb;
    modeT  prev;
    bit    commit;
    nb     = lifeNext(mBoard);
    prev   = mMode;
    commit = 0;
    if (clear) begin
      mBoard = '0;
      mGen   = 0;
      mPhase = 0;
      mMode  = M_PAUSED;
    end else begin
      if (ev) begin
        if (prev != M_RUNNING && row < N && col < N) begin
          mBoard[row][col] = val;
          mMode = M_PAUSED;
        end
      end else if (prev == M_PAUSED && !pause) begin
        if (run) begin
          mMode  = M_RUNNING;
          mPhase = 0;
        end else if (step) begin
          commit = 1;
        end
      end
      if (prev == M_RUNNING) begin
        if (mPhase == DIV - 1) begin
          commit = 1;
          mPhase = 0;
        end else begin
          mPhase++;
        end
        if (pause && !ev) begin
          mMode = M_PAUSED;
        end else if (commit && (nb == mBoard || nb == '0)) begin
          mMode = M_HALTED;
        end
      end
      if (commit) begin
        mBoard = nb;
        mGen   = (mGen + 1) % (1 << GW);
      end
    end
    mTick = commit;
  endtask

  task automatic compareModel(input string tag);
    checkOutput({tag, ".board"},   64'(evoPrev),  64'(mBoard));
    checkOutput({tag, ".running"}, 64'(running),  64'(mMode == M_RUNNING));
    checkOutput({tag, ".halted"},  64'(halted),   64'(mMode == M_HALTED));
    checkOutput({tag, ".gen"},     64'(genCount), 64'(mGen));
    checkOutput({tag, ".tick"},    64'(genTick),  64'(mTick));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic applyStimulus(input string tag, input bit run, input bit pause, input bit step,
                               input bit clear, input bit ev, input int row, input int col,
                               input bit val);
    cmdRun    = run;
    cmdPause  = pause;
    cmdStep   = step;
    cmdClear  = clear;
    editValid = ev;
    editRow   = 3'(row);
    editCol   = 3'(col);
    editValue = val;
    @(posedge clock);
    modelStep(run, pause, step, clear, ev, row, col, val);
    #1;
    compareModel(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) applyStimulus(tag, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic edit(input string tag, input int row, input int col, input bit val);
    applyStimulus(tag, 0, 0, 0, 0, 1, row, col, val);
  endtask

  task automatic loadBlinker();
    applyStimulus("clr", 0, 0, 0, 1, 0, 0, 0, 0);
    edit("blk", 1, 0, 1);
    edit("blk", 1, 1, 1);
    edit("blk", 1, 2, 1);
  endtask

  initial begin
    boardT expB;
    bit    b0, b1, b2, b3, b4;

    reset = 1'b1;
    {cmdRun, cmdPause, cmdStep, cmdClear, editValid, editValue} = '0;
    editRow = '0;
    editCol = '0;
    modelReset();
    #12;
    compareModel("reset");
    reset = 1'b0;

    // Blinker single step.
    loadBlinker();
    applyStimulus("step", 0, 0, 1, 0, 0, 0, 0, 0);
    expB = '0;
    expB[0][1] = 1'b1;
    expB[1][1] = 1'b1;
    expB[2][1] = 1'b1;
    checkOutput("blinkStep.board", 64'(evoPrev), 64'(expB));
    checkOutput("blinkStep.gen", 64'(genCount), 64'd1);
    checkOutput("blinkStep.tick", 64'(genTick), 64'd1);
    idle("afterStep", 1);
    checkOutput("blinkStep.tickDrop", 64'(genTick), 64'd0);

    // Blinker free-running: commits every DIV edges, never halts.
    loadBlinker();
    applyStimulus("run", 1, 0, 0, 0, 0, 0, 0, 0);
    idle("blinkRun", 3 * DIV);
    checkOutput("blinkRun.gen", 64'(genCount), 64'd3);
    checkOutput("blinkRun.halted", 64'(halted), 64'd0);
    applyStimulus("pause", 0, 1, 0, 0, 0, 0, 0, 0);

    // Still-life block halts on its first running commit; step is then ignored.
    applyStimulus("clr", 0, 0, 0, 1, 0, 0, 0, 0);
    edit("blk", 0, 0, 1);
    edit("blk", 0, 1, 1);
    edit("blk", 1, 0, 1);
    edit("blk", 1, 1, 1);
    applyStimulus("run", 1, 0, 0, 0, 0, 0, 0, 0);
    idle("still", DIV);
    checkOutput("still.halted", 64'(halted), 64'd1);
    checkOutput("still.gen", 64'(genCount), 64'd1);
    applyStimulus("haltStep", 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("haltStep.gen", 64'(genCount), 64'd1);

    // Lone cell dies out; an edit leaves HALTED.
    applyStimulus("clr", 0, 0, 0, 1, 0, 0, 0, 0);
    edit("lone", 2, 2, 1);
    applyStimulus("run", 1, 0, 0, 0, 0, 0, 0, 0);
    idle("extinct", DIV);
    checkOutput("extinct.board", 64'(evoPrev), 64'd0);
    checkOutput("extinct.halted", 64'(halted), 64'd1);
    edit("reEdit", 0, 0, 1);
    checkOutput("reEdit.board", 64'(evoPrev), 64'd1);
    checkOutput("reEdit.halted", 64'(halted), 64'd0);

    // Edit ignored while running; clear on the terminal tick suppresses the commit.
    loadBlinker();
    applyStimulus("run", 1, 0, 0, 0, 0, 0, 0, 0);
    edit("runEdit", 3, 3, 1);
    checkOutput("runEdit.cell", 64'(evoPrev[3][3]), 64'd0);
    idle("runIdle", DIV - 2);
    applyStimulus("clrTick", 0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("clrTick.board", 64'(evoPrev), 64'd0);
    checkOutput("clrTick.gen", 64'(genCount), 64'd0);
    checkOutput("clrTick.tick", 64'(genTick), 64'd0);
    checkOutput("clrTick.running", 64'(running), 64'd0);

    // Asynchronous reset in the middle of a generation.
    loadBlinker();
    applyStimulus("run", 1, 0, 0, 0, 0, 0, 0, 0);
    idle("preReset", 2);
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("asyncReset.board", 64'(evoPrev), 64'd0);
    checkOutput("asyncReset.running", 64'(running), 64'd0);
    checkOutput("asyncReset.gen", 64'(genCount), 64'd0);
    compareModel("asyncReset");
    #2;
    reset = 1'b0;
    edit("rowOob", 5, 0, 1);
    checkOutput("rowOob.board", 64'(evoPrev), 64'd0);

    // Randomised command mix, including overlapping commands and off-board edits.
    for (int k = 0; k < 600; k++) begin
      b0 = ($urandom_range(0, 99) < 2);
      b1 = ($urandom_range(0, 99) < 20);
      b2 = ($urandom_range(0, 99) < 4);
      b3 = ($urandom_range(0, 99) < 6);
      b4 = ($urandom_range(0, 99) < 6);
      applyStimulus("rand", b3, b2, b4, b0, b1, int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
